// File: rtl/chrisruk_matrix_pkg.sv
// Shared constants, state encoding and the frame-word lookup for the
// 8x8 APA102 running-dot driver.
package chrisruk_matrix_pkg;

   localparam int WORD_BITS = 32;

   localparam logic [WORD_BITS-1:0] START_WORD = 32'h0000_0000;
   localparam logic [WORD_BITS-1:0] END_WORD   = 32'hFFFF_FFFF;
   localparam logic [WORD_BITS-1:0] LED_ON     = 32'hE100_00FF;  // brightness 1, red FF
   localparam logic [WORD_BITS-1:0] LED_OFF    = 32'hE000_0000;

   typedef enum logic {
      WAIT = 1'b0,
      SEND = 1'b1
   } state_e;

   // Word idx of a frame: 0 is the start frame, 1..num_leds are LEDs
   // (LED index idx-1), anything beyond is the end frame.
   function automatic logic [WORD_BITS-1:0] frame_word(input logic [6:0] idx,
                                                       input logic [5:0] pos,
                                                       input int         num_leds);
      if (idx == 7'd0)
         return START_WORD;
      else if (int'(idx) > num_leds)
         return END_WORD;
      else if ((idx - 7'd1) == {1'b0, pos})
         return LED_ON;
      else
         return LED_OFF;
   endfunction

endpackage

// File: rtl/chrisruk_matrix_if.sv
// Word handshake between the frame sequencer and the serializer.
// valid/ready: a word transfers on a rising clk edge where load and ready
// are both high; word must be stable whenever load is high, and load may
// be dropped only after the transfer.
interface chrisruk_matrix_if;
   import chrisruk_matrix_pkg::*;

   logic [WORD_BITS-1:0] word;
   logic                 load;
   logic                 ready;

   modport master (output word, output load, input  ready);
   modport slave  (input  word, input  load, output ready);

endinterface

// File: rtl/chrisruk_matrix_apa102_serializer.sv
// Shifts 32-bit words out MSB first as APA102 clock/data, two clk cycles
// per bit (clock low with data, then clock high with data held). Ready is
// raised during the last high phase so back-to-back words leave no gap.
module chrisruk_matrix_apa102_serializer
   import chrisruk_matrix_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   chrisruk_matrix_if.slave     ser_s,
   output logic                 clock_1_o,
   output logic                 strip_1_o
);

   logic                 busy_q,  busy_d;
   logic [4:0]           bit_q,   bit_d;
   logic [WORD_BITS-1:0] sh_q,    sh_d;
   logic                 clk1_q,  clk1_d;
   logic                 dat_q,   dat_d;
   logic                 last_h;

   assign last_h      = busy_q & clk1_q & (bit_q == 5'(WORD_BITS - 1));
   assign ser_s.ready = ~busy_q | last_h;
   assign clock_1_o   = clk1_q;
   assign strip_1_o   = dat_q;

   // Next-state: load a new word, finish the current one, or advance a phase.
   always_comb begin
      busy_d = busy_q;
      bit_d  = bit_q;
      sh_d   = sh_q;
      clk1_d = clk1_q;
      dat_d  = dat_q;
      if (ser_s.load && ser_s.ready) begin
         busy_d = 1'b1;
         bit_d  = '0;
         dat_d  = ser_s.word[WORD_BITS-1];
         sh_d   = {ser_s.word[WORD_BITS-2:0], 1'b0};
         clk1_d = 1'b0;
      end else if (last_h) begin
         busy_d = 1'b0;
         bit_d  = '0;
         clk1_d = 1'b0;
         dat_d  = 1'b0;
      end else if (busy_q) begin
         if (!clk1_q) begin
            clk1_d = 1'b1;
         end else begin
            clk1_d = 1'b0;
            dat_d  = sh_q[WORD_BITS-1];
            sh_d   = {sh_q[WORD_BITS-2:0], 1'b0};
            bit_d  = bit_q + 5'd1;
         end
      end
   end

   // Serializer registers; reset drops both LED lines immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         bit_q  <= '0;
         sh_q   <= '0;
         clk1_q <= 1'b0;
         dat_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         bit_q  <= bit_d;
         sh_q   <= sh_d;
         clk1_q <= clk1_d;
         dat_q  <= dat_d;
      end
   end

endmodule

// File: rtl/chrisruk_matrix.sv
// Running-dot driver for an APA102 LED chain on a TinyTapeout-style tile.
// WAIT idles MAX_COUNT clocks; the last WAIT clock hands the start word to
// the serializer so the frame follows without a gap. SEND feeds the LED and
// end words, then returns to WAIT and advances the lit position.
module chrisruk_matrix
   import chrisruk_matrix_pkg::*;
#(
   parameter int MAX_COUNT = 10_000_000,
   parameter int NUM_LEDS  = 64
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam int          CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
   localparam logic [6:0]  LAST_WORD = 7'(NUM_LEDS + 1);

   logic clk;
   logic rst;
   logic unused_io;

   assign clk       = io_in[0];
   assign rst       = io_in[1];
   assign unused_io = &{1'b0, io_in[7:2]};

   state_e             state_q,    state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [6:0]         word_q,     word_d;
   logic [5:0]         pos_q,      pos_d;
   logic               clock_1;
   logic               strip_1;

   chrisruk_matrix_if ser_bus ();

   chrisruk_matrix_apa102_serializer u_ser (
      .clk_i     (clk),
      .rst_i     (rst),
      .ser_s     (ser_bus.slave),
      .clock_1_o (clock_1),
      .strip_1_o (strip_1)
   );

   assign io_out = {6'b000000, strip_1, clock_1};

   // Sequencer next-state: idle counter, word index and lit position.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      word_d       = word_q;
      pos_d        = pos_q;
      ser_bus.load = 1'b0;
      ser_bus.word = START_WORD;
      case (state_q)
         WAIT: begin
            if (wait_cnt_q == CNT_W'(MAX_COUNT - 1)) begin
               wait_cnt_d   = '0;
               ser_bus.load = 1'b1;
               ser_bus.word = START_WORD;
               if (ser_bus.ready) begin
                  word_d  = 7'd1;
                  state_d = SEND;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         SEND: begin
            if (word_q <= LAST_WORD) begin
               ser_bus.load = 1'b1;
               ser_bus.word = frame_word(word_q, pos_q, NUM_LEDS);
               if (ser_bus.ready)
                  word_d = word_q + 7'd1;
            end else if (ser_bus.ready) begin
               // ready here means the final high phase of the end word
               state_d = WAIT;
               word_d  = '0;
               pos_d   = (pos_q == 6'(NUM_LEDS - 1)) ? 6'd0 : pos_q + 6'd1;
            end
         end
         default: state_d = WAIT;
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT;
         wait_cnt_q <= '0;
         word_q     <= '0;
         pos_q      <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         word_q     <= word_d;
         pos_q      <= pos_d;
      end
   end

endmodule

// File: tb/tb_chrisruk_matrix.sv
// Bench for chrisruk_matrix: a 64-LED instance (latency, frame content,
// period, mid-frame reset) and a 4-LED instance (position wrap), both with
// MAX_COUNT=100 and random activity on the unused input bits.
module tb_chrisruk_matrix;

   localparam int MAXC     = 100;
   localparam int NL_A     = 64;
   localparam int NL_B     = 4;
   localparam int RISES_A  = 2112;   // 32 * 66
   localparam int PERIOD_A = 4324;   // 100 + 64 * 66

   logic       clk   = 1'b0;
   logic       rst_a = 1'b1;
   logic       rst_b = 1'b1;
   logic [5:0] junk  = 6'd0;
   logic [7:0] io_in_a, io_in_b, io_out_a, io_out_b;

   assign io_in_a = {junk, rst_a, clk};
   assign io_in_b = {junk, rst_b, clk};

   chrisruk_matrix #(.MAX_COUNT(MAXC), .NUM_LEDS(NL_A)) dut_a (
      .io_in  (io_in_a),
      .io_out (io_out_a)
   );

   chrisruk_matrix #(.MAX_COUNT(MAXC), .NUM_LEDS(NL_B)) dut_b (
      .io_in  (io_in_b),
      .io_out (io_out_b)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   longint cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- scoreboard state ----------------
   int          checks   = 0;
   int          failures = 0;
   int          hi_bad   = 0;
   longint      rel_cyc_a = 0;
   logic [31:0] exp_a_q[$];
   logic [31:0] exp_b_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_frame(input bit on_a, input int nl, input int pos);
      for (int w = 0; w < nl + 2; w++) begin
         logic [31:0] v;
         if (w == 0)            v = 32'h0000_0000;
         else if (w == nl + 1)  v = 32'hFFFF_FFFF;
         else if (w - 1 == pos) v = 32'hE100_00FF;
         else                   v = 32'hE000_0000;
         if (on_a) exp_a_q.push_back(v);
         else      exp_b_q.push_back(v);
      end
   endtask

   task automatic wait_q(input bit on_a, input int target, input int budget, input string name);
      int n = 0;
      while (((on_a ? exp_a_q.size() : exp_b_q.size()) > target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, on_a ? exp_a_q.size() : exp_b_q.size(), target);
   endtask

   // ---------------- unused input noise ----------------
   initial forever begin
      @(negedge clk);
      junk = 6'($urandom_range(0, 63));
   end

   // ---------------- monitor ----------------
   logic        prev_a = 1'b0, prev_b = 1'b0;
   logic [31:0] sh_a = '0, sh_b = '0;
   int          nb_a = 0, nb_b = 0, rises_a = 0;
   longint      last_rise_a = -1, frame_start_a = -1;

   initial forever begin
      @(negedge clk);
      if (io_out_a[7:2] !== 6'd0 || io_out_b[7:2] !== 6'd0) hi_bad++;

      if (rst_a) begin
         nb_a = 0; prev_a = 1'b0; rises_a = 0;
         last_rise_a = -1; frame_start_a = -1;
      end else begin
         if (io_out_a[0] && !prev_a) begin
            if (last_rise_a < 0 || cyc - last_rise_a != 2) begin
               if (frame_start_a < 0) begin
                  check("first_rise_latency", 64'(cyc - rel_cyc_a), 64'(MAXC + 1));
               end else begin
                  check("rises_per_frame", rises_a, RISES_A);
                  check("frame_period", 64'(cyc - frame_start_a), PERIOD_A);
               end
               frame_start_a = cyc;
               rises_a = 0;
            end
            rises_a++;
            last_rise_a = cyc;
            sh_a = {sh_a[30:0], io_out_a[1]};
            nb_a++;
            if (nb_a == 32) begin
               nb_a = 0;
               if (exp_a_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL word_a_extra: got %08h with nothing expected", sh_a);
               end else begin
                  check("word_a", sh_a, exp_a_q.pop_front());
               end
            end
         end
         prev_a = io_out_a[0];
      end

      if (rst_b) begin
         nb_b = 0; prev_b = 1'b0;
      end else begin
         if (io_out_b[0] && !prev_b) begin
            sh_b = {sh_b[30:0], io_out_b[1]};
            nb_b++;
            if (nb_b == 32) begin
               nb_b = 0;
               if (exp_b_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL word_b_extra: got %08h with nothing expected", sh_b);
               end else begin
                  check("word_b", sh_b, exp_b_q.pop_front());
               end
            end
         end
         prev_b = io_out_b[0];
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_out_a", io_out_a, 8'h00);
      check("reset_out_b", io_out_b, 8'h00);

      push_frame(1'b1, NL_A, 0);
      push_frame(1'b1, NL_A, 1);
      push_frame(1'b1, NL_A, 2);
      for (int f = 0; f < 7; f++) push_frame(1'b0, NL_B, f % NL_B);  // lit 0,1,2,3,0,1,2

      rst_a = 1'b0;
      rst_b = 1'b0;
      rel_cyc_a = cyc;

      for (int i = 1; i <= MAXC; i++) begin
         @(negedge clk);
         check("idle_out_a", io_out_a, 8'h00);
      end

      wait_q(1'b0, 0, 4000, "b_frames_done");
      rst_b = 1'b1;

      wait_q(1'b1, 0, 14000, "a_frames_done");

      // Abort frame 3 (LED 3 lit) during word 10 with clock_1 high.
      push_frame(1'b1, NL_A, 3);
      wait_q(1'b1, 56, 2000, "a_reach_word10");
      begin
         int n = 0;
         while (!io_out_a[0] && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("clk_high_before_abort", io_out_a[0], 1'b1);
      end
      #2 rst_a = 1'b1;
      #1 check("async_reset_a", io_out_a[1:0], 2'b00);
      exp_a_q.delete();
      push_frame(1'b1, NL_A, 0);
      repeat (3) @(negedge clk);
      check("held_reset_a", io_out_a, 8'h00);
      rst_a = 1'b0;
      rel_cyc_a = cyc;

      wait_q(1'b1, 0, 5000, "a_after_reset_done");
      repeat (20) @(negedge clk);

      check("upper_bits_zero", hi_bad, 0);
      check("b_no_leftover", exp_b_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
